// File: rtl/difftest_commit_sequencer.sv
// Serialises two commit slots into one in-order difftest stream through a FIFO.
// Also keeps retire/skip counters, a sticky overflow flag and a no-commit watchdog.
module difftest_commit_sequencer #(
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 5000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] diff_0_pc,
   input  logic [31:0] diff_0_inst,
   input  logic        diff_0_commit,
   input  logic        diff_0_skip,
   input  logic [31:0] diff_1_pc,
   input  logic [31:0] diff_1_inst,
   input  logic        diff_1_commit,
   input  logic        diff_1_skip,
   output logic        in_ready,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst,
   output logic        out_skip,
   output logic [63:0] commit_cnt,
   output logic [31:0] skip_cnt,
   output logic        overflow,
   output logic        hang
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int WW = $clog2(TIMEOUT + 1);

   logic [31:0]      r_pc   [DEPTH];
   logic [31:0]      r_inst [DEPTH];
   logic [DEPTH-1:0] r_skip;
   logic [AW-1:0]    r_rd;
   logic [AW-1:0]    r_wr;
   logic [CW-1:0]    r_count;
   logic [WW-1:0]    r_wdog;
   logic [63:0]      r_commit_cnt;
   logic [31:0]      r_skip_cnt;
   logic             r_overflow;
   logic             r_hang;

   logic [CW-1:0] w_free;
   logic          w_any;
   logic          w_acc;
   logic          w_wr0;
   logic          w_wr1;
   logic [AW-1:0] w_wr1_idx;
   logic [1:0]    w_n_enq;
   logic          w_deq;

   // in_ready looks only at registered occupancy, never at this cycle's dequeue
   assign w_free    = CW'(DEPTH) - r_count;
   assign in_ready  = w_free >= CW'(2);
   assign out_valid = r_count != '0;
   assign w_any     = diff_0_commit | diff_1_commit;
   assign w_acc     = w_any & in_ready;
   assign w_wr0     = w_acc & diff_0_commit;
   assign w_wr1     = w_acc & diff_1_commit;
   assign w_wr1_idx = r_wr + AW'(w_wr0);
   assign w_n_enq   = {1'b0, w_wr0} + {1'b0, w_wr1};
   assign w_deq     = out_valid & out_ready;

   assign out_pc     = r_pc[r_rd];
   assign out_inst   = r_inst[r_rd];
   assign out_skip   = r_skip[r_rd];
   assign commit_cnt = r_commit_cnt;
   assign skip_cnt   = r_skip_cnt;
   assign overflow   = r_overflow;
   assign hang       = r_hang;

   always_ff @(posedge clock) begin
      if (w_wr0) begin
         r_pc[r_wr]   <= diff_0_pc;
         r_inst[r_wr] <= diff_0_inst;
         r_skip[r_wr] <= diff_0_skip;
      end
      if (w_wr1) begin
         r_pc[w_wr1_idx]   <= diff_1_pc;
         r_inst[w_wr1_idx] <= diff_1_inst;
         r_skip[w_wr1_idx] <= diff_1_skip;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_rd         <= '0;
         r_wr         <= '0;
         r_count      <= '0;
         r_wdog       <= '0;
         r_commit_cnt <= '0;
         r_skip_cnt   <= '0;
         r_overflow   <= 1'b0;
         r_hang       <= 1'b0;
      end else begin
         r_count <= r_count + CW'(w_n_enq) - CW'(w_deq);
         r_wr    <= r_wr + AW'(w_n_enq);
         if (w_deq) begin
            r_rd         <= r_rd + AW'(1);
            r_commit_cnt <= r_commit_cnt + 64'd1;
            r_skip_cnt   <= r_skip_cnt + 32'(out_skip);
         end
         if (w_any && !in_ready)
            r_overflow <= 1'b1;
         if (w_n_enq != 2'd0)
            r_wdog <= '0;
         else if (r_wdog != WW'(TIMEOUT))
            r_wdog <= r_wdog + WW'(1);
         if (r_wdog == WW'(TIMEOUT))
            r_hang <= 1'b1;
      end
   end
endmodule
